// File: rtl/conv_tile_scheduler.sv
// conv_tile_scheduler
// Walks one convolution layer as a sequence of GEMM tile requests. After
// start, the output feature-map size is found by a restoring division,
// then one tile per (kernel group, oy, ox) is offered to the img2col/GEMM
// datapath, with kgrp outermost and ox innermost. The number of issued but
// not yet retired tiles is capped at MAX_OUT, and conv_done pulses once the
// last issued tile has been retired.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   start           one-cycle launch pulse (honoured only in IDLE)
//   tensor_size     ifmap edge T
//   kernel_size     kernel edge K
//   stride          stride S
//   kernel_nums     kernel count N
//   busy            layer in progress (including the conv_done cycle)
//   cfg_err         one-cycle pulse on a rejected configuration
//   tile_valid      tile request valid
//   tile_ready      datapath accepts the tile
//   tile_oy/ox      output pixel coordinates
//   tile_row_base   oy*S, ifmap window row origin
//   tile_col_base   ox*S, ifmap window column origin
//   tile_kgrp       kernel group index
//   tile_last       final tile of the layer
//   tile_done       one pulse per retired tile
//   conv_done       one-cycle pulse when the layer is complete
//   ofs             output feature map size
//   dbg_state       current FSM state (0 IDLE, 1 CALC, 2 ISSUE, 3 DRAIN)
//
// Handshake: a tile transfers on a rising edge where tile_valid and
// tile_ready are both high. Once raised, tile_valid and the payload stay
// stable until that transfer; tile_ready may toggle freely.
module conv_tile_scheduler #(
    parameter int TENSOR_W = 8,
    parameter int KERNEL_W = 4,
    parameter int STRIDE_W = 3,
    parameter int KNUM_W   = 8,
    parameter int PE_COLS  = 8,
    parameter int MAX_OUT  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [TENSOR_W-1:0] tensor_size,
    input  logic [KERNEL_W-1:0] kernel_size,
    input  logic [STRIDE_W-1:0] stride,
    input  logic [KNUM_W-1:0]   kernel_nums,
    output logic                busy,
    output logic                cfg_err,
    output logic                tile_valid,
    input  logic                tile_ready,
    output logic [TENSOR_W-1:0] tile_oy,
    output logic [TENSOR_W-1:0] tile_ox,
    output logic [TENSOR_W-1:0] tile_row_base,
    output logic [TENSOR_W-1:0] tile_col_base,
    output logic [KNUM_W-1:0]   tile_kgrp,
    output logic                tile_last,
    input  logic                tile_done,
    output logic                conv_done,
    output logic [TENSOR_W-1:0] ofs,
    output logic [1:0]          dbg_state
);

    localparam int GRP_SH = $clog2(PE_COLS);
    localparam int PW     = TENSOR_W + STRIDE_W;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_CALC  = 2'd1,
        S_ISSUE = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

    state_t              state_q, state_d;
    logic [STRIDE_W-1:0] s_q, s_d;
    logic [KNUM_W-1:0]   n_q, n_d;
    logic [TENSOR_W-1:0] rem_q, rem_d;
    logic [TENSOR_W-1:0] quo_q, quo_d;
    logic [TENSOR_W-1:0] ofs_q, ofs_d;
    logic [KNUM_W-1:0]   ngrp_q, ngrp_d;
    logic [KNUM_W-1:0]   kgrp_q, kgrp_d;
    logic [TENSOR_W-1:0] oy_q, oy_d;
    logic [TENSOR_W-1:0] ox_q, ox_d;
    logic [TENSOR_W-1:0] row_base_q, row_base_d;
    logic [TENSOR_W-1:0] col_base_q, col_base_d;
    logic [3:0]          out_cnt_q, out_cnt_d;
    logic                tile_valid_q, tile_valid_d;
    logic                tile_last_q, tile_last_d;
    logic                busy_q, busy_d;
    logic                cfg_err_q, cfg_err_d;
    logic                conv_done_q, conv_done_d;

    logic                hs;
    logic                done_eff;
    logic                bad_cfg;
    logic [KNUM_W:0]     n_round;

    assign hs       = tile_valid_q & tile_ready;
    // A retire with nothing outstanding is a stray pulse; drop it.
    assign done_eff = tile_done & (out_cnt_q != 4'd0);
    assign bad_cfg  = (kernel_size == '0) || (stride == '0) || (kernel_nums == '0) ||
                      (int'(kernel_size) > int'(tensor_size));
    // ceil(N / PE_COLS) as add-then-shift.
    assign n_round  = {1'b0, n_q} + (KNUM_W+1)'(PE_COLS - 1);

    always_comb begin
        state_d     = state_q;
        s_d         = s_q;
        n_d         = n_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        ofs_d       = ofs_q;
        ngrp_d      = ngrp_q;
        kgrp_d      = kgrp_q;
        oy_d        = oy_q;
        ox_d        = ox_q;
        cfg_err_d   = 1'b0;
        conv_done_d = 1'b0;
        out_cnt_d   = out_cnt_q + {3'b000, hs} - {3'b000, done_eff};

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    s_d   = stride;
                    n_d   = kernel_nums;
                    ofs_d = '0;
                    if (bad_cfg) begin
                        cfg_err_d = 1'b1;
                    end else begin
                        state_d = S_CALC;
                        rem_d   = tensor_size - TENSOR_W'(kernel_size);
                        quo_d   = '0;
                        kgrp_d  = '0;
                        oy_d    = '0;
                        ox_d    = '0;
                    end
                end
            end
            S_CALC: begin
                // One restoring-division step: quo ends at floor((T-K)/S).
                if (rem_q >= TENSOR_W'(s_q)) begin
                    rem_d = rem_q - TENSOR_W'(s_q);
                    quo_d = quo_q + TENSOR_W'(1);
                end else begin
                    ofs_d   = quo_q + TENSOR_W'(1);
                    ngrp_d  = KNUM_W'(n_round >> GRP_SH);
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (hs) begin
                    if (tile_last_q) begin
                        state_d = S_DRAIN;
                    end else if (ox_q == ofs_q - TENSOR_W'(1)) begin
                        ox_d = '0;
                        if (oy_q == ofs_q - TENSOR_W'(1)) begin
                            oy_d   = '0;
                            kgrp_d = kgrp_q + KNUM_W'(1);
                        end else begin
                            oy_d = oy_q + TENSOR_W'(1);
                        end
                    end else begin
                        ox_d = ox_q + TENSOR_W'(1);
                    end
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == 4'd0) begin
                    conv_done_d = 1'b1;
                    state_d     = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Decided on next-cycle occupancy so the cap is never exceeded.
        tile_valid_d = (state_d == S_ISSUE) && (out_cnt_d != 4'(MAX_OUT));
        tile_last_d  = (state_d == S_ISSUE) &&
                       (kgrp_d == ngrp_d - KNUM_W'(1)) &&
                       (oy_d == ofs_d - TENSOR_W'(1)) &&
                       (ox_d == ofs_d - TENSOR_W'(1));
        // Product never exceeds T-K, so truncation loses nothing.
        row_base_d   = TENSOR_W'(PW'(oy_d) * PW'(s_q));
        col_base_d   = TENSOR_W'(PW'(ox_d) * PW'(s_q));
        busy_d       = (state_d != S_IDLE) || conv_done_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            s_q          <= '0;
            n_q          <= '0;
            rem_q        <= '0;
            quo_q        <= '0;
            ofs_q        <= '0;
            ngrp_q       <= '0;
            kgrp_q       <= '0;
            oy_q         <= '0;
            ox_q         <= '0;
            row_base_q   <= '0;
            col_base_q   <= '0;
            out_cnt_q    <= '0;
            tile_valid_q <= 1'b0;
            tile_last_q  <= 1'b0;
            busy_q       <= 1'b0;
            cfg_err_q    <= 1'b0;
            conv_done_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            s_q          <= s_d;
            n_q          <= n_d;
            rem_q        <= rem_d;
            quo_q        <= quo_d;
            ofs_q        <= ofs_d;
            ngrp_q       <= ngrp_d;
            kgrp_q       <= kgrp_d;
            oy_q         <= oy_d;
            ox_q         <= ox_d;
            row_base_q   <= row_base_d;
            col_base_q   <= col_base_d;
            out_cnt_q    <= out_cnt_d;
            tile_valid_q <= tile_valid_d;
            tile_last_q  <= tile_last_d;
            busy_q       <= busy_d;
            cfg_err_q    <= cfg_err_d;
            conv_done_q  <= conv_done_d;
        end
    end

    assign busy          = busy_q;
    assign cfg_err       = cfg_err_q;
    assign tile_valid    = tile_valid_q;
    assign tile_oy       = oy_q;
    assign tile_ox       = ox_q;
    assign tile_row_base = row_base_q;
    assign tile_col_base = col_base_q;
    assign tile_kgrp     = kgrp_q;
    assign tile_last     = tile_last_q;
    assign conv_done     = conv_done_q;
    assign ofs           = ofs_q;
    assign dbg_state     = state_q;

endmodule

// File: tb/tb_conv_tile_scheduler.sv
// Directed bench for conv_tile_scheduler with default parameters
// (8-bit tensor, PE_COLS=8, MAX_OUT=4).
module tb_conv_tile_scheduler;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  tensor_size;
    logic [3:0]  kernel_size;
    logic [2:0]  stride;
    logic [7:0]  kernel_nums;
    logic        busy;
    logic        cfg_err;
    logic        tile_valid;
    logic        tile_ready;
    logic [7:0]  tile_oy;
    logic [7:0]  tile_ox;
    logic [7:0]  tile_row_base;
    logic [7:0]  tile_col_base;
    logic [7:0]  tile_kgrp;
    logic        tile_last;
    logic        tile_done;
    logic        conv_done;
    logic [7:0]  ofs;
    logic [1:0]  dbg_state;

    int errs = 0;
    int checks = 0;

    logic [40:0] act_payload;
    logic [54:0] all_out;
    assign act_payload = {tile_kgrp, tile_oy, tile_ox, tile_row_base, tile_col_base, tile_last};
    assign all_out     = {busy, cfg_err, tile_valid, tile_oy, tile_ox, tile_row_base,
                          tile_col_base, tile_kgrp, tile_last, conv_done, ofs, dbg_state};

    conv_tile_scheduler dut (
        .clk           (clk),
        .rst           (rst),
        .start         (start),
        .tensor_size   (tensor_size),
        .kernel_size   (kernel_size),
        .stride        (stride),
        .kernel_nums   (kernel_nums),
        .busy          (busy),
        .cfg_err       (cfg_err),
        .tile_valid    (tile_valid),
        .tile_ready    (tile_ready),
        .tile_oy       (tile_oy),
        .tile_ox       (tile_ox),
        .tile_row_base (tile_row_base),
        .tile_col_base (tile_col_base),
        .tile_kgrp     (tile_kgrp),
        .tile_last     (tile_last),
        .tile_done     (tile_done),
        .conv_done     (conv_done),
        .ofs           (ofs),
        .dbg_state     (dbg_state)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Expected payload of tile number idx in kgrp/oy/ox loop order.
    function automatic logic [40:0] exp_payload(input int idx, input int ofs_e,
                                                input int s, input int total);
        int kg, oy, ox;
        kg = idx / (ofs_e * ofs_e);
        oy = (idx / ofs_e) % ofs_e;
        ox = idx % ofs_e;
        return {8'(kg), 8'(oy), 8'(ox), 8'(oy * s), 8'(ox * s), (idx == total - 1)};
    endfunction

    task automatic launch(input int t, input int k, input int s, input int n);
        tensor_size = 8'(t);
        kernel_size = 4'(k);
        stride      = 3'(s);
        kernel_nums = 8'(n);
        start       = 1'b1;
        step();
        start       = 1'b0;
    endtask

    // Full layer with a datapath that retires each tile one cycle after its
    // handshake; optional 10-cycle tile_ready drop before tile stall_at.
    task automatic run_layer(input string name, input int t, input int k, input int s,
                             input int n, input int ofs_e, input int ngrp_e,
                             input int calc_e, input int stall_at);
        int total, idx, c, stall_left, conv_cnt, extra_valid;
        logic [40:0] exp;
        bit pending, stalled, hs;
        total = ngrp_e * ofs_e * ofs_e;
        tile_ready = 1'b1;
        tile_done  = 1'b0;
        launch(t, k, s, n);
        checks++;
        if (dbg_state !== 2'd1 || busy !== 1'b1)
            $display("FAIL %s calc_entry: state=%0d busy=%0b want state=1 busy=1", name, dbg_state, busy);
        c = 0;
        while (!tile_valid && c < 200) begin
            step();
            c++;
        end
        checks++;
        if (c !== calc_e) begin
            errs++;
            $display("FAIL %s calc_cycles: got %0d want %0d", name, c, calc_e);
        end
        checks++;
        if (ofs !== 8'(ofs_e)) begin
            errs++;
            $display("FAIL %s ofs: got %0d want %0d", name, ofs, ofs_e);
        end
        idx = 0; c = 0; pending = 0; stalled = 0; stall_left = 0;
        while (idx < total && c < 5000) begin
            if (!stalled && idx == stall_at) begin
                stalled    = 1;
                stall_left = 10;
            end
            if (stall_left > 0) begin
                tile_ready = 1'b0;
                exp = exp_payload(idx, ofs_e, s, total);
                checks++;
                if (tile_valid !== 1'b1 || act_payload !== exp) begin
                    errs++;
                    $display("FAIL %s stall_hold idx=%0d: valid=%0b payload=%h want valid=1 payload=%h",
                             name, idx, tile_valid, act_payload, exp);
                end
                stall_left--;
            end else begin
                tile_ready = 1'b1;
            end
            hs = tile_valid && tile_ready;
            if (hs) begin
                exp = exp_payload(idx, ofs_e, s, total);
                checks++;
                if (act_payload !== exp) begin
                    errs++;
                    $display("FAIL %s tile idx=%0d: payload=%h want %h", name, idx, act_payload, exp);
                end
                idx++;
            end
            tile_done = pending;
            pending   = hs;
            step();
            c++;
        end
        checks++;
        if (idx !== total) begin
            errs++;
            $display("FAIL %s tile_count: got %0d want %0d", name, idx, total);
        end
        tile_ready = 1'b1;
        conv_cnt = 0;
        extra_valid = 0;
        for (int i = 0; i < 12; i++) begin
            tile_done = pending;
            pending   = 0;
            if (tile_valid) extra_valid++;
            if (conv_done) begin
                conv_cnt++;
                checks++;
                if (busy !== 1'b1) begin
                    errs++;
                    $display("FAIL %s busy_at_done: got %0b want 1", name, busy);
                end
            end
            step();
        end
        tile_done = 1'b0;
        checks++;
        if (conv_cnt !== 1 || extra_valid !== 0 || busy !== 1'b0 || dbg_state !== 2'd0) begin
            errs++;
            $display("FAIL %s finish: conv_done=%0d extra_valid=%0d busy=%0b state=%0d want 1 0 0 0",
                     name, conv_cnt, extra_valid, busy, dbg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; tile_ready = 1'b0; tile_done = 1'b0;
        tensor_size = '0; kernel_size = '0; stride = '0; kernel_nums = '0;
        step();
        step();
        checks++;
        if (all_out !== '0) begin
            errs++;
            $display("FAIL reset_outputs: got %h want 0", all_out);
        end
        rst = 1'b0;
        step();
        checks++;
        if (all_out !== '0) begin
            errs++;
            $display("FAIL reset_release: got %h want 0", all_out);
        end
    endtask

    task automatic test_basic();
        run_layer("basic", 8, 3, 1, 16, 6, 2, 6, -1);
    endtask

    task automatic test_stride();
        run_layer("stride", 7, 3, 2, 5, 3, 1, 3, -1);
    endtask

    task automatic test_back_pressure();
        run_layer("stall", 7, 3, 2, 5, 3, 1, 3, 4);
    endtask

    task automatic test_max_out();
        int h, c;
        tile_ready = 1'b1;
        tile_done  = 1'b0;
        launch(4, 1, 1, 8);
        c = 0;
        while (!tile_valid && c < 50) begin
            step();
            c++;
        end
        h = 0;
        for (int i = 0; i < 12; i++) begin
            if (tile_valid && tile_ready) h++;
            step();
        end
        checks++;
        if (h !== 4 || tile_valid !== 1'b0) begin
            errs++;
            $display("FAIL cap_fill: handshakes=%0d valid=%0b want 4 0", h, tile_valid);
        end
        tile_done = 1'b1;
        step();
        tile_done = 1'b0;
        h = 0;
        for (int i = 0; i < 6; i++) begin
            if (tile_valid && tile_ready) h++;
            step();
        end
        checks++;
        if (h !== 1 || tile_valid !== 1'b0) begin
            errs++;
            $display("FAIL cap_one_retire: handshakes=%0d valid=%0b want 1 0", h, tile_valid);
        end
        tile_done = 1'b1;
        step();
        checks++;
        if (tile_valid !== 1'b1) begin
            errs++;
            $display("FAIL cap_refill: valid=%0b want 1", tile_valid);
        end
        step();
        checks++;
        if (tile_valid !== 1'b1) begin
            errs++;
            $display("FAIL cap_same_cycle: valid=%0b want 1", tile_valid);
        end
        tile_done = 1'b0;
        step();
        checks++;
        if (tile_valid !== 1'b0 || act_payload !== {8'd0, 8'd1, 8'd3, 8'd1, 8'd3, 1'b0}) begin
            errs++;
            $display("FAIL cap_refull: valid=%0b payload=%h want 0 %h", tile_valid, act_payload,
                     {8'd0, 8'd1, 8'd3, 8'd1, 8'd3, 1'b0});
        end
        h = 7;
        c = 0;
        tile_done = 1'b1;
        while (!conv_done && c < 200) begin
            if (tile_valid && tile_ready) h++;
            step();
            c++;
        end
        tile_done = 1'b0;
        checks++;
        if (h !== 16 || conv_done !== 1'b1) begin
            errs++;
            $display("FAIL cap_complete: tiles=%0d conv_done=%0b want 16 1", h, conv_done);
        end
        step();
    endtask

    task automatic test_bad_cfg();
        int tv [3][4] = '{'{8, 9, 1, 8}, '{8, 3, 0, 8}, '{8, 3, 1, 0}};
        int bad;
        for (int v = 0; v < 3; v++) begin
            launch(tv[v][0], tv[v][1], tv[v][2], tv[v][3]);
            checks++;
            if (cfg_err !== 1'b1 || busy !== 1'b0 || dbg_state !== 2'd0) begin
                errs++;
                $display("FAIL bad_cfg%0d pulse: cfg_err=%0b busy=%0b state=%0d want 1 0 0",
                         v, cfg_err, busy, dbg_state);
            end
            bad = 0;
            for (int i = 0; i < 8; i++) begin
                step();
                if (cfg_err || busy || tile_valid) bad++;
            end
            checks++;
            if (bad !== 0) begin
                errs++;
                $display("FAIL bad_cfg%0d quiet: active_cycles=%0d want 0", v, bad);
            end
        end
    endtask

    task automatic test_reset_mid();
        int h, c;
        tile_ready = 1'b1;
        tile_done  = 1'b0;
        launch(8, 3, 1, 16);
        h = 0;
        c = 0;
        while (h < 3 && c < 50) begin
            if (tile_valid) h++;
            step();
            c++;
        end
        tile_ready = 1'b0;
        checks++;
        if (h !== 3 || tile_valid !== 1'b1) begin
            errs++;
            $display("FAIL rst_setup: handshakes=%0d valid=%0b want 3 1", h, tile_valid);
        end
        rst = 1'b1;
        #2;
        checks++;
        if (all_out !== '0) begin
            errs++;
            $display("FAIL rst_async: got %h want 0", all_out);
        end
        rst = 1'b0;
        h = 0;
        for (int i = 0; i < 4; i++) begin
            tile_done = (i < 3);
            step();
            if (busy || conv_done || tile_valid) h++;
        end
        tile_done = 1'b0;
        checks++;
        if (h !== 0) begin
            errs++;
            $display("FAIL rst_stray_done: active_cycles=%0d want 0", h);
        end
        run_layer("after_rst", 7, 3, 2, 5, 3, 1, 3, -1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_stride();
        test_back_pressure();
        test_max_out();
        test_bad_cfg();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule

// File: doc/conv_tile_scheduler.md
# conv_tile_scheduler

Sequences one convolution layer onto the img2col GEMM datapath by walking every output pixel position and every kernel group, issuing one tile request per (kernel group, oy, ox) over a valid/ready handshake. It sits between the layer-parameter registers (tensor size, kernel size, stride, kernel count) and the img2col gather and GEMM array. It bounds the number of in-flight tiles and raises `conv_done` once every issued tile has been retired by the datapath.

## Interface
- `TENSOR_W`, default 8: width of tensor size and all pixel coordinates.
- `KERNEL_W`, default 4: width of kernel size.
- `STRIDE_W`, default 3: width of stride.
- `KNUM_W`, default 8: width of kernel count.
- `PE_COLS`, default 8: kernels processed per tile. Must be a power of 2.
- `MAX_OUT`, default 4: maximum number of in-flight tiles (1..15).
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that launches a layer.
- `tensor_size` in TENSOR_W: input feature map edge T (square).
- `kernel_size` in KERNEL_W: kernel edge K.
- `stride` in STRIDE_W: stride S.
- `kernel_nums` in KNUM_W: kernel count N.
- `busy` out 1: high while a layer is in progress.
- `cfg_err` out 1: one-cycle pulse when a configuration is rejected.
- `tile_valid` out 1: tile request valid.
- `tile_ready` in 1: datapath accepts the tile.
- `tile_oy`, `tile_ox` out TENSOR_W: output pixel coordinates.
- `tile_row_base`, `tile_col_base` out TENSOR_W: ifmap window origin, equal to oy*S and ox*S.
- `tile_kgrp` out KNUM_W: kernel group index.
- `tile_last` out 1: marks the final tile of the layer.
- `tile_done` in 1: one-cycle pulse from the datapath, one per retired tile.
- `conv_done` out 1: one-cycle pulse when the layer is complete.
- `ofs` out TENSOR_W: computed output feature map size, valid from ISSUE onward and held until the next start.

## Operation
- Reset values: all outputs are 0; state is IDLE; all counters are 0.
- IDLE: on `start`, latch T, K, S and N.
  - If K==0, S==0, N==0 or K>T: pulse `cfg_err` and stay in IDLE.
  - Otherwise go to CALC with rem=T-K and q=0.
  - `start` is ignored in every state other than IDLE.
- CALC: runs one restoring-division step per cycle.
  - If rem>=S: rem-=S and q+=1.
  - Otherwise: set ofs=q+1, set ngrp=ceil(N/PE_COLS) (shift plus round-up), and go to ISSUE.
  - CALC therefore lasts floor((T-K)/S)+1 cycles.
- ISSUE: walks the tiles in loop order kgrp (outer), oy, then ox (inner).
  - `tile_valid` and payload are registered and held stable until `tile_valid & tile_ready`.
  - On handshake, advance to the next tile in the following cycle.
  - `tile_last` is high when kgrp==ngrp-1, oy==ofs-1 and ox==ofs-1.
  - After the last handshake, deassert `tile_valid` and go to DRAIN.
- Outstanding counter `out_cnt`:
  - +1 on handshake, -1 on `tile_done`.
  - If both occur in the same cycle, the counter is unchanged.
  - `tile_done` while `out_cnt==0` is ignored, with no underflow.
  - `tile_valid` is 0 in any cycle where `out_cnt==MAX_OUT` (registered decision based on the next `out_cnt`).
- DRAIN: when `out_cnt` reaches 0, pulse `conv_done` for one cycle and return to IDLE.
- `busy` is high in CALC, ISSUE and DRAIN, and in the `conv_done` cycle.
- `rst` mid-operation immediately clears all state and outputs. In-flight tiles are abandoned, and no `conv_done` is raised for them.
- Widths:
  - oy*S is computed at TENSOR_W+STRIDE_W bits and truncated to TENSOR_W. This is legal because oy*S <= T-K.
  - The total tile count is never stored; termination uses the `tile_last` condition only.

## Timing
- `start` sampled high at edge k: CALC begins at edge k+1.
- First `tile_valid` is high at edge k+1+q+1, where q=floor((T-K)/S).
- With `tile_ready` held high and `tile_done` returned every cycle, one tile is issued per cycle.
- `conv_done` asserts at the edge after `out_cnt` reaches 0 in DRAIN.
- `cfg_err` asserts at edge k+1, and `busy` never rises.

## Test plan
- T=8, K=3, S=1, N=16, `tile_ready` high, `tile_done` one cycle after each handshake: CALC takes 6 cycles, ofs=6, 72 tiles issued. Order is (0,0,0),(0,0,1)…(1,5,5). `tile_last` is high only on tile 72. One `conv_done`.
- T=7, K=3, S=2, N=5: ofs=3, ngrp=1, 9 tiles. tile (oy=2,ox=1) has row_base=4 and col_base=2.
- `tile_ready` low for 10 cycles mid-layer: `tile_valid` and payload are held constant and no tile is skipped or duplicated.
- MAX_OUT=4, `tile_done` withheld: exactly 4 handshakes, then `tile_valid`=0. One `tile_done` restores one issue. A same-cycle handshake plus `tile_done` keeps `out_cnt` unchanged.
- Bad configurations K=9 with T=8, S=0, and N=0: each gives a `cfg_err` pulse, `busy`=0 and no `tile_valid`.
- `rst` pulsed during ISSUE with 3 tiles outstanding: all outputs return to 0. A subsequent valid `start` runs a full layer normally, and stray `tile_done` pulses after reset are ignored.
